// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter that shares one parity checker among N_REQ FIFOs, forwarding good words
// and dropping bad ones. Optional sticky per-source error mask: define PARITY_ARB_ERR_MASK_EN.

module parity_check_arbiter #(
  parameter int    N_REQ      = 4,
  parameter int    ERR_CNT_W  = 8,
  // Word geometry, kept in step with fifo_package (DATA_WIDTH = WIDTH + 1 parity bit)
  parameter int    DATA_WIDTH = 9,
  parameter int    WIDTH      = 8,
  parameter string PARITY_BIT = "MSB",
  localparam int   SRC_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_grant_o,
  output logic [DATA_WIDTH-1:0]       chk_data_o,
  output logic                        chk_valid_o,
  output logic                        chk_grant_o,
  input  logic                        chk_valid_i,
  input  logic                        out_grant_i,
`ifdef PARITY_ARB_ERR_MASK_EN
  input  logic [N_REQ-1:0]            err_clr_i,
  output logic [N_REQ-1:0]            err_mask_o,
`endif
  output logic                        out_valid_o,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [SRC_W-1:0]            out_src_o,
  output logic                        err_o,
  output logic [SRC_W-1:0]            err_src_o,
  output logic [ERR_CNT_W-1:0]        err_cnt_o
);

  // state | meaning
  // IDLE  | nothing held; pop the round-robin winner as soon as any source is eligible
  // HOLD  | one word held and shown to the checker; retire when downstream is ready
  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       hold_src;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic [SRC_W-1:0]       err_src;
  logic [ERR_CNT_W-1:0]   err_cnt;

  logic                   in_hold;
  logic                   hold_pass;
  logic                   hold_fail;
  logic                   load;
  logic                   retire;
  logic [N_REQ-1:0]       eligible;
  logic                   any_elig;
  logic [SRC_W-1:0]       arb_base;
  logic [SRC_W-1:0]       winner;
  logic [WIDTH-1:0]       stripped;
  logic [DATA_WIDTH-1:0]  req_word [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign req_word[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Reset gates every combinational output so nothing is popped or reported in the reset cycle.
  assign in_hold   = (state == HOLD) && !rst;
  assign hold_pass = in_hold && out_grant_i && chk_valid_i;
  assign hold_fail = in_hold && out_grant_i && !chk_valid_i;

`ifdef PARITY_ARB_ERR_MASK_EN
  logic [N_REQ-1:0] err_mask;
  logic [N_REQ-1:0] mask_set;

  // A failing source is excluded already in the cycle it fails, not only from the next one.
  assign mask_set   = hold_fail ? (N_REQ'(1) << hold_src) : '0;
  assign eligible   = req_valid_i & ~(err_mask | mask_set);
  assign err_mask_o = err_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_mask <= '0;
    end else begin
      err_mask <= (err_mask | mask_set) & ~err_clr_i;
    end
  end
`else
  assign eligible = req_valid_i;
`endif

  // On retire the search restarts after the source just served, so back-to-back pops stay fair.
  assign arb_base = (state == HOLD) ? hold_src : rr_ptr;

  always_comb begin
    int               idx;
    logic [SRC_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    winner   = '0;
    any_elig = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(arb_base) + k) % N_REQ;
      cand = idx[SRC_W-1:0];
      if (!any_elig && eligible[cand]) begin
        any_elig = 1'b1;
        winner   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_grant_i) begin
          retire = 1'b1;
          if (any_elig) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      load   = 1'b0;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= SRC_W'(N_REQ - 1);
      hold_data <= '0;
      hold_src  <= '0;
      err_src   <= '0;
      err_cnt   <= '0;
    end else begin
      if (retire) begin
        rr_ptr <= hold_src;
      end
      if (load) begin
        hold_data <= req_word[winner];
        hold_src  <= winner;
      end
      if (hold_fail) begin
        err_src <= hold_src;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  if (PARITY_BIT == "LSB") begin : g_strip_lsb
    assign stripped = hold_data[DATA_WIDTH-1:1];
  end else begin : g_strip_msb
    assign stripped = hold_data[WIDTH-1:0];
  end

  assign req_grant_o = load ? (N_REQ'(1) << winner) : '0;
  assign chk_data_o  = in_hold ? hold_data : '0;
  assign chk_valid_o = in_hold;
  assign chk_grant_o = in_hold && out_grant_i;
  assign out_valid_o = hold_pass;
  assign out_data_o  = in_hold ? stripped : '0;
  assign out_src_o   = in_hold ? hold_src : '0;
  assign err_o       = hold_fail;
  assign err_src_o   = err_src;
  assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Bench for parity_check_arbiter: FIFO bank and parity checker modelled in the bench, every
// cycle compared against a transaction-level reference. Mask checks follow PARITY_ARB_ERR_MASK_EN.

module tb_parity_check_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid_i;
  logic [35:0]  req_data_i;
  logic [3:0]   req_grant_o;
  logic [8:0]   chk_data_o;
  logic         chk_valid_o;
  logic         chk_grant_o;
  logic         chk_valid_i;
  logic         out_grant_i;
  logic         out_valid_o;
  logic [7:0]   out_data_o;
  logic [1:0]   out_src_o;
  logic         err_o;
  logic [1:0]   err_src_o;
  logic [7:0]   err_cnt_o;
  logic [3:0]   err_clr;
`ifdef PARITY_ARB_ERR_MASK_EN
  logic [3:0]   err_mask_o;
`endif

  parity_check_arbiter #(.N_REQ(4), .ERR_CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_grant_o (req_grant_o),
    .chk_data_o  (chk_data_o),
    .chk_valid_o (chk_valid_o),
    .chk_grant_o (chk_grant_o),
    .chk_valid_i (chk_valid_i),
    .out_grant_i (out_grant_i),
`ifdef PARITY_ARB_ERR_MASK_EN
    .err_clr_i   (err_clr),
    .err_mask_o  (err_mask_o),
`endif
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .err_o       (err_o),
    .err_src_o   (err_src_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  // Checker stand-in: a held word passes when its nine bits hold an odd number of ones.
  assign chk_valid_i = chk_valid_o & (^chk_data_o);

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] fq [4][$];

  bit         m_hold = 1'b0;
  logic [8:0] m_word = '0;
  int         m_src  = 0;
  int         m_ptr  = N - 1;
  int         m_cnt  = 0;
  int         m_esrc = 0;
  logic [3:0] m_mask = '0;
  int         m_win;
  bit         m_retire;
  bit         m_fail;

  bit         rec = 1'b0;
  logic [3:0] gq [$];
  int         n_err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input bit good);
    logic [7:0] d;
    d = 8'($urandom);
    return {good ? ~^d : ^d, d};
  endfunction

  // Winner = eligible source at the smallest circular distance after base.
  function automatic int pick(input int base, input logic [3:0] elig);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - base - 1 + 2 * N) % N;
      if (elig[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]          = (fq[i].size() != 0);
      req_data_i[i*9 +: 9]    = (fq[i].size() != 0) ? fq[i][0] : 9'h0;
    end
  endtask

  task automatic check_cycle();
    logic [3:0] set_v;
    logic [3:0] exp_grant;
    bit         ok;
    ok       = ^m_word;
    m_retire = !rst && m_hold && out_grant_i;
    m_fail   = m_retire && !ok;
    set_v    = '0;
`ifdef PARITY_ARB_ERR_MASK_EN
    if (m_fail) set_v[m_src] = 1'b1;
`endif
    m_win = -1;
    if (!rst && (!m_hold || m_retire))
      m_win = pick(m_hold ? m_src : m_ptr, req_valid_i & ~(m_mask | set_v));
    exp_grant = (m_win >= 0) ? (4'b0001 << m_win) : 4'b0000;

    chk("req_grant",   req_grant_o, exp_grant);
    chk("chk_valid",   chk_valid_o, !rst && m_hold);
    chk("chk_grant",   chk_grant_o, m_retire);
    chk("chk_data",    chk_data_o,  (!rst && m_hold) ? m_word : 9'h0);
    chk("out_valid",   out_valid_o, m_retire && ok);
    chk("out_data",    out_data_o,  (!rst && m_hold) ? m_word[7:0] : 8'h0);
    chk("out_src",     out_src_o,   (!rst && m_hold) ? m_src : 0);
    chk("err",         err_o,       m_fail);
    chk("err_src",     err_src_o,   m_esrc);
    chk("err_cnt",     err_cnt_o,   m_cnt);
`ifdef PARITY_ARB_ERR_MASK_EN
    chk("err_mask",    err_mask_o,  m_mask);
`endif
    if (rec && req_grant_o != 4'b0000) gq.push_back(req_grant_o);
    if (err_o === 1'b1) n_err_seen++;
  endtask

  task automatic update_model();
    if (rst) begin
      m_hold = 1'b0;
      m_ptr  = N - 1;
      m_cnt  = 0;
      m_esrc = 0;
      m_mask = '0;
      return;
    end
    if (m_retire) begin
      m_ptr = m_src;
      if (m_fail) begin
        if (m_cnt < 255) m_cnt++;
        m_esrc = m_src;
`ifdef PARITY_ARB_ERR_MASK_EN
        m_mask[m_src] = 1'b1;
`endif
      end
    end
`ifdef PARITY_ARB_ERR_MASK_EN
    m_mask = m_mask & ~err_clr;
`endif
    if (m_win >= 0) begin
      m_word = fq[m_win].pop_front();
      m_src  = m_win;
      m_hold = 1'b1;
    end else if (m_retire) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      drive_inputs();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst         = 1'b1;
    out_grant_i = 1'b0;
    err_clr     = 4'b0000;
    req_valid_i = '0;
    req_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    step(2);
    rst = 1'b0;

    // Single good word from FIFO 2, then a failing word from FIFO 1.
    out_grant_i = 1'b1;
    fq[2].push_back(9'h100);
    step(3);
    fq[1].push_back(9'h000);
    step(3);
    chk("err_cnt_after_one", err_cnt_o, 1);
    chk("err_src_after_one", err_src_o, 1);

    // All four FIFOs busy: grant order 0,1,2,3,0,1,2,3 with no bubbles.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) fq[k % 4].push_back(mk(1'b1));
    rec = 1'b1;
    step(8);
    rec = 1'b0;
    step(2);
    chk("grant_seq_len", gq.size(), 8);
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      if (k < gq.size()) chk("grant_seq", gq[k], exp_g);
    end

    // Downstream stall of five cycles, with a competing request arriving meanwhile.
    fq[0].push_back(mk(1'b1));
    step(1);
    out_grant_i = 1'b0;
    fq[1].push_back(mk(1'b1));
    step(5);
    out_grant_i = 1'b1;
    step(4);

    // Long run of failing words from FIFO 3 drives the counter into saturation.
    n_err_seen = 0;
    for (int k = 0; k < 260; k++) fq[3].push_back(mk(1'b0));
    step(262);
    chk("err_pulses", n_err_seen, 260);
    chk("err_cnt_sat", err_cnt_o, 8'hFF);

    // Reset in the middle of HOLD drops the held word; FIFO 0 wins afterwards.
    fq[2].push_back(mk(1'b1));
    out_grant_i = 1'b0;
    step(2);
    fq[0].push_back(mk(1'b1));
    fq[1].push_back(mk(1'b1));
    rst         = 1'b1;
    out_grant_i = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);

`ifdef PARITY_ARB_ERR_MASK_EN
    // FIFO 3 errs, stays masked until cleared.
    fq[3].push_back(mk(1'b0));
    step(2);
    fq[3].push_back(mk(1'b1));
    fq[0].push_back(mk(1'b1));
    step(3);
    chk("mask3_pending", fq[3].size(), 1);
    err_clr = 4'b1000;
    step(1);
    err_clr = 4'b0000;
    step(3);
    chk("mask3_drained", fq[3].size(), 0);
`endif

    // Randomized traffic: pushes, good/bad words, downstream stalls, occasional reset.
    for (int c = 0; c < 400; c++) begin
      int s;
      s = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0 && fq[s].size() < 4)
        fq[s].push_back(mk($urandom_range(0, 3) != 0));
      out_grant_i = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 63) == 0);
      err_clr     = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      step(1);
    end
    rst     = 1'b0;
    err_clr = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
